// File: rtl/sync_stuff_pkg.sv
// Shared types and constants for the 1101-sync framing transmitter.
// The recognizer step function is shared by the tracker and the transmitter.
package sync_stuff_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, STUFF} tx_state_t;
  typedef enum logic [1:0] {R0, R1, R2, R3} shadow_t;

  localparam logic [3:0] SYNC_PATTERN = 4'b1101;
  localparam int         SYNC_LEN     = 4;

  // One step of the overlapping 1101 recognizer: R1="1", R2="11", R3="110".
  function automatic shadow_t next_shadow(input shadow_t s, input logic b);
    case (s)
      R0:      return b ? R1 : R0;
      R1:      return b ? R2 : R0;
      R2:      return b ? R2 : R3;
      default: return b ? R1 : R0;
    endcase
  endfunction

endpackage

// File: rtl/shadow_tracker.sv
// Registered state of an overlapping 1101 recognizer watching a serial line.
module shadow_tracker
  import sync_stuff_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    bit_in,
  output shadow_t shadow
);

  // NOTE: sequential state is always written with <= so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) shadow <= R0;
    else       shadow <= next_shadow(shadow, bit_in);
  end

endmodule

// File: rtl/sync_stuff_tx.sv
// Frames a parallel word as 1101 + payload (MSB first) on line w, inserting
// stuff 0s so a downstream 1101 recognizer only ever fires on the sync marker.
module sync_stuff_tx
  import sync_stuff_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              w,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  tx_state_t         state;
  shadow_t           shadow;
  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        sync_idx;
  logic              w_nxt;

  logic accept, bits_left, sync_last, in_payload, do_bit, do_stuff;

  assign ready_out  = (state == IDLE) && (shadow != R3) && !reset;
  assign accept     = valid_in && ready_out;
  assign bits_left  = (cnt != CNT_W'(DATA_W));
  assign sync_last  = (sync_idx == 2'(SYNC_LEN - 1));
  assign in_payload = (state == SYNC && sync_last) || state == DATA || state == STUFF;
  assign do_stuff   = in_payload && bits_left && (shadow == R3);
  assign do_bit     = in_payload && bits_left && (shadow != R3);

  // The tracker consumes the bit about to be registered onto w, so its
  // output always reflects the line including the current cycle's w.
  always_comb begin
    // NOTE: w_nxt gets a default first so no path through this block can
    // leave it unassigned and infer a latch.
    w_nxt = 1'b0;
    if (state == IDLE)                 w_nxt = accept & SYNC_PATTERN[SYNC_LEN-1];
    else if (state == SYNC && !sync_last) w_nxt = SYNC_PATTERN[2'(SYNC_LEN-2) - sync_idx];
    else if (do_bit)                   w_nxt = sreg[DATA_W-1];
  end

  shadow_tracker u_shadow (
    .clk    (clk),
    .reset  (reset),
    .bit_in (w_nxt),
    .shadow (shadow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      w          <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      // NOTE: the payload register is reset only to keep simulation free of
      // X; it is always reloaded on accept before being shifted out.
      sreg       <= '0;
      cnt        <= '0;
      sync_idx   <= '0;
    end else begin
      w          <= w_nxt;
      frame_done <= do_bit && (cnt == CNT_W'(DATA_W - 1));
      case (state)
        IDLE: begin
          if (accept) begin
            sreg     <= data_in;
            cnt      <= '0;
            sync_idx <= '0;
            state    <= SYNC;
            busy     <= 1'b1;
          end
        end
        default: begin
          if (state == SYNC && !sync_last) begin
            sync_idx <= sync_idx + 2'd1;
          end else if (do_bit) begin
            sreg  <= {sreg[DATA_W-2:0], 1'b0};
            cnt   <= cnt + CNT_W'(1);
            state <= DATA;
          end else if (do_stuff) begin
            state <= STUFF;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_stuff_tx.sv
// Bench for sync_stuff_tx: expected line contents come from a bit-history
// model of the framing/stuffing rules; an independent 1101 counter watches w.
module tb_sync_stuff_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_out, w, busy, frame_done;

  int   total = 0;
  int   bad   = 0;
  int   det   = 0;
  logic [3:0] hist = 4'b0;
  bit   exp_q[$];
  int   gap;

  sync_stuff_tx #(.DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .w          (w),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Counts 1101 occurrences on w using the value held during the ending cycle.
  always @(posedge clk) begin
    if (reset) hist <= 4'b0;
    else begin
      hist <= {hist[2:0], w};
      if ({hist[2:0], w} == 4'b1101) det <= det + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  // Expected line: sync marker, then payload MSB-first with a 0 inserted
  // whenever the line so far ends in 110 and payload bits remain.
  task automatic build_frame(input logic [DW-1:0] word);
    exp_q.delete();
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    for (int i = DW - 1; i >= 0; i--) begin
      int n;
      n = exp_q.size();
      if (exp_q[n-3] && exp_q[n-2] && !exp_q[n-1]) exp_q.push_back(1'b0);
      exp_q.push_back(word[i]);
    end
    gap = (exp_q[$] && exp_q[$-1]) ? 2 : 1;
  endtask

  // Sends one word (entered right after a negedge) and checks every bit,
  // the status outputs, the idle gap and the detection count.
  task automatic send_frame(input logic [DW-1:0] word, input string name);
    int guard, det0, len;
    guard = 0;
    while (ready_out !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    total++;
    if (ready_out !== 1'b1) begin
      bad++; $display("FAIL %s ready_wait ready_out=%b want 1", name, ready_out);
    end
    build_frame(word);
    len = exp_q.size();
    det0 = det;
    valid_in = 1'b1; data_in = word;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      valid_in = 1'b0; data_in = DW'($urandom);
      total++;
      if ({w, busy, ready_out, frame_done} !== {exp_q[i], 1'b1, 1'b0, (i == len - 1)}) begin
        bad++;
        $display("FAIL %s bit%0d {w,busy,ready,done}=%b want %b", name, i,
                 {w, busy, ready_out, frame_done}, {exp_q[i], 1'b1, 1'b0, (i == len - 1)});
      end
      if (i == 4) begin
        total++;
        if (det !== det0 + 1) begin
          bad++; $display("FAIL %s sync_detect det=%0d want %0d", name, det - det0, 1);
        end
      end
    end
    @(negedge clk);
    total++;
    if ({w, busy, frame_done, ready_out} !== {3'b000, (gap == 1)}) begin
      bad++;
      $display("FAIL %s idle1 {w,busy,done,ready}=%b want %b", name,
               {w, busy, frame_done, ready_out}, {3'b000, (gap == 1)});
    end
    if (gap == 2) begin
      @(negedge clk);
      total++;
      if ({w, busy, frame_done, ready_out} !== 4'b0001) begin
        bad++;
        $display("FAIL %s idle2 {w,busy,done,ready}=%b want 0001", name,
                 {w, busy, frame_done, ready_out});
      end
    end
    total++;
    if (det !== det0 + 1) begin
      bad++; $display("FAIL %s detect_count got=%0d want 1", name, det - det0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b1; data_in = 8'hA5;
    repeat (3) @(negedge clk);
    total++;
    if ({w, busy, frame_done, ready_out} !== 4'b0000) begin
      bad++; $display("FAIL reset_state {w,busy,done,ready}=%b want 0000",
                      {w, busy, frame_done, ready_out});
    end
    valid_in = 1'b0; reset = 1'b0;
    @(negedge clk);
    total++;
    if ({w, busy, frame_done, ready_out} !== 4'b0001) begin
      bad++; $display("FAIL reset_release {w,busy,done,ready}=%b want 0001",
                      {w, busy, frame_done, ready_out});
    end
  endtask

  task automatic test_fixed_words();
    send_frame(8'h00, "word_00");
    send_frame(8'hFF, "word_ff");
    send_frame(8'hD0, "word_d0");
    send_frame(8'hB6, "word_b6");
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] dn_seen;
    build_frame(8'hFF);
    dn_seen = 4'b0;
    valid_in = 1'b1; data_in = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      total++;
      if ({w, busy} !== {exp_q[i], 1'b1}) begin
        bad++; $display("FAIL midrst bit%0d {w,busy}=%b want %b", i, {w, busy}, {exp_q[i], 1'b1});
      end
      dn_seen[0] = dn_seen[0] | frame_done;
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({w, busy, frame_done, ready_out} !== 4'b0000) begin
      bad++; $display("FAIL midrst_edge {w,busy,done,ready}=%b want 0000",
                      {w, busy, frame_done, ready_out});
    end
    reset = 1'b0;
    @(negedge clk);
    dn_seen[0] = dn_seen[0] | frame_done;
    total++;
    if ({w, busy, dn_seen[0], ready_out} !== 4'b0001) begin
      bad++; $display("FAIL midrst_after {w,busy,done_seen,ready}=%b want 0001",
                      {w, busy, dn_seen[0], ready_out});
    end
  endtask

  // valid_in stays high across three frames while data_in churns every cycle;
  // the intended word is present only on the cycle the model predicts accept.
  task automatic test_back_to_back();
    logic [DW-1:0] words [3];
    int len, det0;
    words[0] = 8'hD0; words[1] = 8'hB6; words[2] = 8'h00;
    valid_in = 1'b1;
    for (int f = 0; f < 3; f++) begin
      total++;
      if ({ready_out, busy, w} !== 3'b100) begin
        bad++; $display("FAIL b2b%0d accept_slot {ready,busy,w}=%b want 100", f, {ready_out, busy, w});
      end
      build_frame(words[f]);
      len = exp_q.size();
      det0 = det;
      data_in = words[f];
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        data_in = DW'($urandom);
        total++;
        if ({w, busy, ready_out, frame_done} !== {exp_q[i], 1'b1, 1'b0, (i == len - 1)}) begin
          bad++;
          $display("FAIL b2b%0d bit%0d {w,busy,ready,done}=%b want %b", f, i,
                   {w, busy, ready_out, frame_done}, {exp_q[i], 1'b1, 1'b0, (i == len - 1)});
        end
      end
      @(negedge clk);
      for (int j = 1; j < gap; j++) begin
        total++;
        if ({ready_out, busy, w} !== 3'b000) begin
          bad++; $display("FAIL b2b%0d gap {ready,busy,w}=%b want 000", f, {ready_out, busy, w});
        end
        data_in = DW'($urandom);
        @(negedge clk);
      end
      total++;
      if (det !== det0 + 1) begin
        bad++; $display("FAIL b2b%0d detect_count got=%0d want 1", f, det - det0);
      end
    end
    valid_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if ({busy, w} !== 2'b00) begin
        bad++; $display("FAIL b2b_extra cyc%0d {busy,w}=%b want 00", i, {busy, w});
      end
    end
  endtask

  task automatic test_random_words();
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(DW'($urandom), $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = '0;
    @(negedge clk);
    test_reset();
    test_fixed_words();
    test_reset_mid_frame();
    test_back_to_back();
    test_random_words();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
